// File: rtl/adder_controller.sv
// Sequencing controller for a four-operand adder datapath (A+B+C+D).
// Moore FSM; every control output is registered from the next-state decode.
module adder_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       aload,
    output logic       bload,
    output logic       cload,
    output logic       dload,
    output logic       asel,
    output logic [1:0] bsel,
    output logic       output_enable,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [7:0] op_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ADD_AB = 3'd2,
        S_ADD_C  = 3'd3,
        S_ADD_D  = 3'd4,
        S_OUTPUT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic       aload;
        logic       bload;
        logic       cload;
        logic       dload;
        logic       asel;
        logic [1:0] bsel;
        logic       output_enable;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t     state_r;
    state_t     state_next_s;
    ctrl_t      ctrl_r;
    logic       abort_take_s;
    logic       aborted_r;
    logic [7:0] op_count_r;

    // Output decode for a state; anything unrecognised (including 7) decodes as IDLE.
    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0, asel: 1'b0,
              bsel: 2'b11, output_enable: 1'b0, busy: 1'b0, done: 1'b0};
        case (st)
            S_LOAD: begin
                c.aload = 1'b1;
                c.bload = 1'b1;
                c.cload = 1'b1;
                c.dload = 1'b1;
                c.busy  = 1'b1;
            end
            S_ADD_AB: begin
                c.asel = 1'b1;
                c.bsel = 2'b00;
                c.busy = 1'b1;
            end
            S_ADD_C: begin
                c.bsel = 2'b01;
                c.busy = 1'b1;
            end
            S_ADD_D: begin
                c.bsel = 2'b10;
                c.busy = 1'b1;
            end
            S_OUTPUT: begin
                c.output_enable = 1'b1;
                c.busy          = 1'b1;
            end
            S_DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c.busy = 1'b0;
            end
        endcase
        return c;
    endfunction

    // Next-state logic; abort wins over start and only pulses when a sequence is cancelled.
    always_comb begin
        state_next_s = S_IDLE;
        abort_take_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_next_s = S_LOAD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD, S_ADD_AB, S_ADD_C, S_ADD_D, S_OUTPUT: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                    abort_take_s = 1'b1;
                end else begin
                    case (state_r)
                        S_LOAD:   state_next_s = S_ADD_AB;
                        S_ADD_AB: state_next_s = S_ADD_C;
                        S_ADD_C:  state_next_s = S_ADD_D;
                        S_ADD_D:  state_next_s = S_OUTPUT;
                        S_OUTPUT: state_next_s = S_DONE;
                        default:  state_next_s = S_IDLE;
                    endcase
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, registered control outputs, abort pulse and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ctrl_r     <= decode_ctrl(S_IDLE);
            aborted_r  <= 1'b0;
            op_count_r <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            ctrl_r    <= decode_ctrl(state_next_s);
            aborted_r <= abort_take_s;
            if (state_next_s == S_DONE) begin
                op_count_r <= op_count_r + 8'd1;
            end else begin
                op_count_r <= op_count_r;
            end
        end
    end

    assign aload         = ctrl_r.aload;
    assign bload         = ctrl_r.bload;
    assign cload         = ctrl_r.cload;
    assign dload         = ctrl_r.dload;
    assign asel          = ctrl_r.asel;
    assign bsel          = ctrl_r.bsel;
    assign output_enable = ctrl_r.output_enable;
    assign busy          = ctrl_r.busy;
    assign done          = ctrl_r.done;
    assign aborted       = aborted_r;
    assign op_count      = op_count_r;
    assign state         = state_r;

endmodule

// File: tb/tb_adder_controller.sv
// Scoreboard bench for adder_controller: a sequence-position model predicts every
// output each cycle; accepted sequences queue their expected sum and count for the done monitor.
module tb_adder_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       aload, bload, cload, dload, asel, output_enable;
    logic       busy, done, aborted;
    logic [1:0] bsel;
    logic [7:0] op_count;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    logic [7:0] op_a, op_b, op_c, op_d;

    // Model: m_pos = -1 idle, 0..4 = LOAD..OUTPUT position in the sequence, 5 = done.
    int   m_pos   = -1;
    int   m_count = 0;
    logic m_abort = 1'b0;
    int   sum_q[$];
    int   cnt_q[$];

    // Behavioural adder datapath steered by the DUT strobes.
    int dp_a, dp_b, dp_c, dp_d, dp_sum, dp_out;

    adder_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .aload(aload), .bload(bload), .cload(cload), .dload(dload),
        .asel(asel), .bsel(bsel), .output_enable(output_enable),
        .busy(busy), .done(done), .aborted(aborted),
        .op_count(op_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic r);
        start = s;
        abort = a;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] exp_vec(input int pos, input int cnt, input logic ab);
        logic [2:0] st;
        logic [1:0] bs;
        st = (pos < 0) ? 3'd0 : 3'(pos + 1);
        bs = (pos == 1) ? 2'b00 : (pos == 2) ? 2'b01 : (pos == 3) ? 2'b10 : 2'b11;
        return {st, (pos >= 0 && pos <= 4), (pos == 5), ab,
                {4{pos == 0}}, (pos == 1), bs, (pos == 4), 8'(cnt)};
    endfunction

    // Reference model of the sequencing rules.
    always @(posedge clk) begin
        if (rst) begin
            m_pos   <= -1;
            m_count <= 0;
            m_abort <= 1'b0;
            sum_q.delete();
            cnt_q.delete();
        end else begin
            m_abort <= 1'b0;
            if (abort) begin
                m_pos <= -1;
                if (m_pos >= 0 && m_pos <= 4) begin
                    m_abort <= 1'b1;
                    void'(sum_q.pop_back());
                    void'(cnt_q.pop_back());
                end
            end else if (m_pos >= 0 && m_pos < 4) begin
                m_pos <= m_pos + 1;
            end else if (m_pos == 4) begin
                m_pos   <= 5;
                m_count <= (m_count + 1) % 256;
            end else if (start) begin
                m_pos <= 0;
                sum_q.push_back(int'(op_a) + int'(op_b) + int'(op_c) + int'(op_d));
                cnt_q.push_back((m_count + 1) % 256);
            end else begin
                m_pos <= -1;
            end
        end
    end

    // Datapath model reacting to the strobes seen before each edge.
    always @(posedge clk) begin
        if (aload) dp_a <= int'(op_a);
        if (bload) dp_b <= int'(op_b);
        if (cload) dp_c <= int'(op_c);
        if (dload) dp_d <= int'(op_d);
        if (asel) dp_sum <= dp_a + dp_b;
        else if (bsel == 2'b01) dp_sum <= dp_sum + dp_c;
        else if (bsel == 2'b10) dp_sum <= dp_sum + dp_d;
        if (output_enable) dp_out <= dp_sum;
    end

    // Monitor: per-cycle output check plus scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (checking) begin
            chk("outputs",
                {10'd0, state, busy, done, aborted, aload, bload, cload, dload,
                 asel, bsel, output_enable, op_count},
                {10'd0, exp_vec(m_pos, m_count, m_abort)});
            if (done === 1'b1) begin
                if (sum_q.size() == 0) begin
                    chk("done_expected", 32'd1, 32'd0);
                end else begin
                    chk("done_sum", 32'(dp_out), 32'(sum_q.pop_front()));
                    chk("done_count", {24'd0, op_count}, 32'(cnt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        start = 1'b0; abort = 1'b0; rst = 1'b1;
        op_a = 8'd3; op_b = 8'd5; op_c = 8'd7; op_d = 8'd9;
        step(1'b0, 1'b0, 1'b1);
        checking = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_count", {24'd0, op_count}, 32'd0);

        // Single sequence with A=3, B=5, C=7, D=9.
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        chk("single_count", {24'd0, op_count}, 32'd1);
        chk("single_sum", 32'(dp_out), 32'd24);

        // start held: three back-to-back sequences.
        repeat (18) step(1'b1, 1'b0, 1'b0);
        chk("b2b_done_state", {29'd0, state}, 32'd6);
        chk("b2b_count", {24'd0, op_count}, 32'd4);
        step(1'b0, 1'b0, 1'b0);

        // Abort while in ADD_C.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_in_add_c", {29'd0, state}, 32'd3);
        step(1'b0, 1'b1, 1'b0);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_pulse", {31'd0, aborted}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_count", {24'd0, op_count}, 32'd4);

        // start and abort together in IDLE.
        step(1'b1, 1'b1, 1'b0);
        chk("start_abort_state", {29'd0, state}, 32'd0);
        chk("start_abort_pulse", {30'd0, aborted, done}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (m_pos == -1 && $urandom_range(0, 3) == 0) begin
                op_a = 8'($urandom); op_b = 8'($urandom);
                op_c = 8'($urandom); op_d = 8'($urandom);
            end
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        // 256 sequences wrap op_count, then reset during ADD_AB.
        step(1'b0, 1'b0, 1'b1);
        repeat (256 * 6) step(1'b1, 1'b0, 1'b0);
        chk("wrap_state", {29'd0, state}, 32'd6);
        chk("wrap_count", {24'd0, op_count}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_in_add_ab", {29'd0, state}, 32'd2);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_mid_state", {29'd0, state}, 32'd0);
        chk("rst_mid_count", {24'd0, op_count}, 32'd0);
        chk("rst_mid_pulses", {30'd0, aborted, done}, 32'd0);

        repeat (8) step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", 32'(sum_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
